// File: rtl/matmul_grid_mem_ctrl.sv
// Memory-side sequencer for a GRID_ROWS x GRID_COLS grid of systolic matmul tiles.
// Arbitrates host load/readout against compute on the A/B/C bank ports. A run feeds
// skewed A/B read addresses, waits for the grid to drain, then writes C back row by row.
//
// Ports:
//   clk_i, resetn_i      clock, synchronous active-low reset
//   start_i, k_len_i     run request and reduction length (sampled in idle only)
//   host_wr_en_i         host write of A/B banks at host_addr_i
//   host_rd_en_i         host read of C bank host_bank_i at host_addr_i
//   host_addr_i          host address
//   host_bank_i          C bank index for readout
//   busy_o, done_o       run in progress / one-cycle end-of-run pulse
//   host_err_o           one-cycle pulse for a rejected or conflicting host request
//   a_en_o, a_addr_o     per-A-bank feed valid and address (bank r at [r*AWIDTH +: AWIDTH])
//   b_en_o, b_addr_o     per-B-bank feed valid and address
//   c_addr_o, c_we_o     shared C address and per-bank write enables
//   c_rd_sel_o           one-hot C readout mux select
//   rd_valid_o           readout data valid on the C mux output
// All outputs are registered.
module matmul_grid_mem_ctrl #(
  parameter int unsigned GRID_ROWS    = 2,
  parameter int unsigned GRID_COLS    = 2,
  parameter int unsigned AWIDTH       = 16,
  parameter int unsigned MEM_DEPTH    = 7,
  parameter int unsigned TILE_SIZE    = 8,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned BANK_W       = 1
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          start_i,
  input  logic [AWIDTH-1:0]             k_len_i,
  input  logic                          host_wr_en_i,
  input  logic                          host_rd_en_i,
  input  logic [AWIDTH-1:0]             host_addr_i,
  input  logic [BANK_W-1:0]             host_bank_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          host_err_o,
  output logic [GRID_ROWS-1:0]          a_en_o,
  output logic [GRID_ROWS*AWIDTH-1:0]   a_addr_o,
  output logic [GRID_COLS-1:0]          b_en_o,
  output logic [GRID_COLS*AWIDTH-1:0]   b_addr_o,
  output logic [AWIDTH-1:0]             c_addr_o,
  output logic [GRID_ROWS-1:0]          c_we_o,
  output logic [GRID_ROWS-1:0]          c_rd_sel_o,
  output logic                          rd_valid_o
);

  localparam int unsigned Skew = (GRID_ROWS > GRID_COLS) ? GRID_ROWS : GRID_COLS;
  localparam logic [AWIDTH-1:0] IdleAddr  = AWIDTH'(MEM_DEPTH - 1);
  localparam logic [AWIDTH-1:0] DrainLast = AWIDTH'(DRAIN_CYCLES - 1);
  localparam logic [AWIDTH-1:0] WbLast    = AWIDTH'(TILE_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StFeed, StDrain, StWb, StDone} state_e;

  state_e state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] k_q, k_d;
  logic [AWIDTH-1:0] feed_last;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [GRID_ROWS-1:0]        a_en_q, a_en_d;
  logic [GRID_ROWS*AWIDTH-1:0] a_addr_q, a_addr_d;
  logic [GRID_COLS-1:0]        b_en_q, b_en_d;
  logic [GRID_COLS*AWIDTH-1:0] b_addr_q, b_addr_d;
  logic [AWIDTH-1:0]           c_addr_q, c_addr_d;
  logic [GRID_ROWS-1:0]        c_we_q, c_we_d;
  logic [GRID_ROWS-1:0]        c_rd_sel_q, c_rd_sel_d;
  // Readout valid trails the C address by two cycles (bank read latency).
  logic rd_s1_q, rd_s2_q, rd_valid_q;

  logic host_ok, wr_acc, rd_acc, bank_ok;

  // Last feed step: n runs 0 .. k+Skew-2 so the most-skewed lane sees all k addresses.
  assign feed_last = k_q + AWIDTH'(Skew) - AWIDTH'(2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          k_d     = k_len_i;
          cnt_d   = '0;
          state_d = (k_len_i == '0) ? StDrain : StFeed;
        end
      end
      StFeed: begin
        if (cnt_q == feed_last) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StWb;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        if (cnt_q == WbLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Host ops only in a quiet idle cycle; start wins over a simultaneous host op.
  always_comb begin
    host_ok = (state_q == StIdle) && !start_i;
    wr_acc  = host_ok && host_wr_en_i;
    rd_acc  = host_ok && host_rd_en_i && !host_wr_en_i;
    bank_ok = 32'(host_bank_i) < GRID_ROWS;
    err_d   = ((host_wr_en_i || host_rd_en_i) && !host_ok) ||
              (host_ok && host_wr_en_i && host_rd_en_i) ||
              (rd_acc && !bank_ok);
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    a_en_d   = '0;
    b_en_d   = '0;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;

    for (int unsigned r = 0; r < GRID_ROWS; r++) begin
      if (state_d == StFeed && cnt_d >= AWIDTH'(r) && cnt_d < AWIDTH'(r) + k_d) begin
        a_en_d[r]                  = 1'b1;
        a_addr_d[r*AWIDTH +: AWIDTH] = cnt_d - AWIDTH'(r);
      end else if (wr_acc) begin
        a_addr_d[r*AWIDTH +: AWIDTH] = host_addr_i;
      end else if (state_d == StIdle || state_d == StDone) begin
        a_addr_d[r*AWIDTH +: AWIDTH] = IdleAddr;
      end
    end

    for (int unsigned c = 0; c < GRID_COLS; c++) begin
      if (state_d == StFeed && cnt_d >= AWIDTH'(c) && cnt_d < AWIDTH'(c) + k_d) begin
        b_en_d[c]                  = 1'b1;
        b_addr_d[c*AWIDTH +: AWIDTH] = cnt_d - AWIDTH'(c);
      end else if (wr_acc) begin
        b_addr_d[c*AWIDTH +: AWIDTH] = host_addr_i;
      end else if (state_d == StIdle || state_d == StDone) begin
        b_addr_d[c*AWIDTH +: AWIDTH] = IdleAddr;
      end
    end

    c_we_d   = (state_d == StWb) ? '1 : '0;
    c_addr_d = c_addr_q;
    if (state_d == StWb) begin
      c_addr_d = cnt_d;
    end else if (rd_acc) begin
      c_addr_d = host_addr_i;
    end

    // Out-of-range bank selects nothing but the readout still completes.
    c_rd_sel_d = '0;
    for (int unsigned i = 0; i < GRID_ROWS; i++) begin
      c_rd_sel_d[i] = rd_acc && (32'(host_bank_i) == i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      a_en_q     <= '0;
      a_addr_q   <= {GRID_ROWS{IdleAddr}};
      b_en_q     <= '0;
      b_addr_q   <= {GRID_COLS{IdleAddr}};
      c_addr_q   <= '0;
      c_we_q     <= '0;
      c_rd_sel_q <= '0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      a_en_q     <= a_en_d;
      a_addr_q   <= a_addr_d;
      b_en_q     <= b_en_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      c_we_q     <= c_we_d;
      c_rd_sel_q <= c_rd_sel_d;
      rd_s1_q    <= rd_acc;
      rd_s2_q    <= rd_s1_q;
      rd_valid_q <= rd_s2_q;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign host_err_o = err_q;
  assign a_en_o     = a_en_q;
  assign a_addr_o   = a_addr_q;
  assign b_en_o     = b_en_q;
  assign b_addr_o   = b_addr_q;
  assign c_addr_o   = c_addr_q;
  assign c_we_o     = c_we_q;
  assign c_rd_sel_o = c_rd_sel_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_matmul_grid_mem_ctrl.sv
// Self-checking bench for matmul_grid_mem_ctrl: reset, a table of host ops, hand-written
// run sequences, then random stimulus against a timeline-based reference model.
module tb_matmul_grid_mem_ctrl;
  localparam int unsigned R  = 2;
  localparam int unsigned C  = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned MD = 7;
  localparam int unsigned TS = 8;
  localparam int unsigned DC = 8;
  localparam int unsigned BW = 2;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn, start, wr_en, rd_en;
  logic [AW-1:0]   k_len, haddr;
  logic [BW-1:0]   hbank;
  logic            busy, done, herr, rd_valid;
  logic [R-1:0]    a_en, c_we, c_rd_sel;
  logic [R*AW-1:0] a_addr;
  logic [C-1:0]    b_en;
  logic [C*AW-1:0] b_addr;
  logic [AW-1:0]   c_addr;

  matmul_grid_mem_ctrl #(
    .GRID_ROWS(R), .GRID_COLS(C), .AWIDTH(AW), .MEM_DEPTH(MD),
    .TILE_SIZE(TS), .DRAIN_CYCLES(DC), .BANK_W(BW)
  ) dut (
    .clk_i(clk), .resetn_i(resetn), .start_i(start), .k_len_i(k_len),
    .host_wr_en_i(wr_en), .host_rd_en_i(rd_en), .host_addr_i(haddr), .host_bank_i(hbank),
    .busy_o(busy), .done_o(done), .host_err_o(herr),
    .a_en_o(a_en), .a_addr_o(a_addr), .b_en_o(b_en), .b_addr_o(b_addr),
    .c_addr_o(c_addr), .c_we_o(c_we), .c_rd_sel_o(c_rd_sel), .rd_valid_o(rd_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: m_j counts cycles since the start edge (0 = idle).
  int          m_j = 0;
  int          m_k = 0;
  logic [15:0] e_a [R];
  logic [15:0] e_b [C];
  logic [15:0] e_c_addr;
  logic        e_busy, e_done, e_err, e_rdv;
  logic [1:0]  e_aen, e_ben, e_cwe, e_sel;
  int          rd_due[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int feed_len(input int k);
    return (k == 0) ? 0 : k + S - 1;
  endfunction

  task automatic model_edge(input logic rstn, input logic st, input logic [15:0] k,
                            input logic wr, input logic rd, input logic [15:0] addr,
                            input logic [1:0] bank);
    bit idle_pre, acc, wacc, racc, bad, feed, wb, dn, en;
    int f, n;
    cyc++;
    if (!rstn) begin
      m_j = 0;
      for (int r = 0; r < R; r++) e_a[r] = 16'(MD - 1);
      for (int c = 0; c < C; c++) e_b[c] = 16'(MD - 1);
      e_c_addr = '0;
      rd_due.delete();
      {e_busy, e_done, e_err, e_rdv} = '0;
      {e_aen, e_ben, e_cwe, e_sel}   = '0;
      return;
    end
    idle_pre = (m_j == 0);
    if (m_j == 0) begin
      if (st) begin
        m_j = 1;
        m_k = int'(k);
      end
    end else begin
      m_j++;
      if (m_j > feed_len(m_k) + DC + TS + 1) m_j = 0;
    end
    acc  = idle_pre && !st;
    wacc = acc && wr;
    racc = acc && rd && !wr;
    bad  = int'(bank) >= R;
    e_err = (wr || rd) && (!acc || (wr && rd) || (racc && bad));

    f    = feed_len(m_k);
    feed = (m_j >= 1) && (m_j <= f);
    wb   = (m_j > f + DC) && (m_j <= f + DC + TS);
    dn   = (m_j != 0) && (m_j == f + DC + TS + 1);
    n    = m_j - 1;
    e_busy = (m_j != 0);
    e_done = dn;

    for (int r = 0; r < R; r++) begin
      en = feed && (n >= r) && (n < r + m_k);
      e_aen[r] = en;
      if (en) e_a[r] = 16'(n - r);
      else if (wacc) e_a[r] = addr;
      else if (m_j == 0 || dn) e_a[r] = 16'(MD - 1);
    end
    for (int c = 0; c < C; c++) begin
      en = feed && (n >= c) && (n < c + m_k);
      e_ben[c] = en;
      if (en) e_b[c] = 16'(n - c);
      else if (wacc) e_b[c] = addr;
      else if (m_j == 0 || dn) e_b[c] = 16'(MD - 1);
    end

    e_cwe = wb ? 2'b11 : 2'b00;
    if (wb) e_c_addr = 16'(m_j - f - DC - 1);
    else if (racc) e_c_addr = addr;
    e_sel = (racc && !bad) ? 2'(1 << bank) : 2'b00;

    e_rdv = 1'b0;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      e_rdv = 1'b1;
      rd_due.delete(0);
    end
    if (racc) rd_due.push_back(cyc + 2);
  endtask

  task automatic check_model();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("host_err", 64'(herr), 64'(e_err));
    chk("a_en", 64'(a_en), 64'(e_aen));
    chk("a_addr", 64'(a_addr), 64'({e_a[1], e_a[0]}));
    chk("b_en", 64'(b_en), 64'(e_ben));
    chk("b_addr", 64'(b_addr), 64'({e_b[1], e_b[0]}));
    chk("c_addr", 64'(c_addr), 64'(e_c_addr));
    chk("c_we", 64'(c_we), 64'(e_cwe));
    chk("c_rd_sel", 64'(c_rd_sel), 64'(e_sel));
    chk("rd_valid", 64'(rd_valid), 64'(e_rdv));
  endtask

  task automatic cycle(input logic rstn, input logic st, input logic [15:0] k,
                       input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [1:0] bank);
    resetn = rstn; start = st; k_len = k; wr_en = wr; rd_en = rd; haddr = addr; hbank = bank;
    @(posedge clk);
    model_edge(rstn, st, k, wr, rd, addr, bank);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 2'd0);
  endtask

  typedef struct {
    logic        wr, rd;
    logic [15:0] addr;
    logic [1:0]  bank;
    logic [15:0] lane, caddr;
    logic [1:0]  sel;
    logic        err, rdv;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    resetn = 1'b0; start = 1'b0; k_len = '0; wr_en = 1'b0; rd_en = 1'b0; haddr = '0; hbank = '0;

    // Reset state.
    cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 2'd0);
    cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 2'd0);
    chk("rst_a_addr", 64'(a_addr), 64'({16'd6, 16'd6}));
    chk("rst_b_addr", 64'(b_addr), 64'({16'd6, 16'd6}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_c_we", 64'(c_we), 64'd0);
    chk("rst_en", 64'({a_en, b_en}), 64'd0);

    // Host op table, applied from idle in order (c_addr holds between entries).
    vt[0] = '{1'b0, 1'b1, 16'd5,      2'd1, 16'd6,      16'd5, 2'b10, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 16'd3,      2'd0, 16'd3,      16'd5, 2'b00, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 16'd9,      2'd0, 16'd9,      16'd5, 2'b00, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 16'd2,      2'd0, 16'd6,      16'd2, 2'b01, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 16'd4,      2'd2, 16'd6,      16'd4, 2'b00, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 16'd7,      2'd3, 16'd6,      16'd7, 2'b00, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b0, 16'd0,      2'd0, 16'd6,      16'd7, 2'b00, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 16'h1234,   2'd1, 16'h1234,   16'd7, 2'b00, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 16'd0, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].bank);
      chk("tbl_a_lane0", 64'(a_addr[15:0]), 64'(vt[i].lane));
      chk("tbl_b_lane1", 64'(b_addr[31:16]), 64'(vt[i].lane));
      chk("tbl_c_addr", 64'(c_addr), 64'(vt[i].caddr));
      chk("tbl_c_rd_sel", 64'(c_rd_sel), 64'(vt[i].sel));
      chk("tbl_host_err", 64'(herr), 64'(vt[i].err));
      idle(1);
      chk("tbl_rdv_early", 64'(rd_valid), 64'd0);
      idle(1);
      chk("tbl_rd_valid", 64'(rd_valid), 64'(vt[i].rdv));
      idle(1);
    end

    // k_len=4 run: feed t1..t5, drain t6..t13, write-back t14..t21, done t22.
    cycle(1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 16'd0, 2'd0);
    for (int j = 1; j <= 23; j++) begin
      if (j > 1) idle(1);
      if (j == 1) begin
        chk("k4_t1_a_en", 64'(a_en), 64'b01);
        chk("k4_t1_a0", 64'(a_addr[15:0]), 64'd0);
        chk("k4_t1_busy", 64'(busy), 64'd1);
      end
      if (j == 4) chk("k4_t4_a_addr", 64'(a_addr), 64'({16'd2, 16'd3}));
      if (j == 5) begin
        chk("k4_t5_a_en", 64'(a_en), 64'b10);
        chk("k4_t5_a1", 64'(a_addr[31:16]), 64'd3);
      end
      if (j == 6)  chk("k4_t6_a_en", 64'(a_en), 64'd0);
      if (j == 13) chk("k4_t13_c_we", 64'(c_we), 64'd0);
      if (j == 14) chk("k4_t14_wb", 64'({c_we, c_addr}), 64'({2'b11, 16'd0}));
      if (j == 21) chk("k4_t21_wb", 64'({c_we, c_addr}), 64'({2'b11, 16'd7}));
      if (j == 22) begin
        chk("k4_t22_done", 64'({done, c_we}), 64'({1'b1, 2'b00}));
        chk("k4_t22_a_addr", 64'(a_addr), 64'({16'd6, 16'd6}));
      end
      if (j == 23) chk("k4_t23_idle", 64'({busy, done}), 64'd0);
    end

    // Host write during feed is rejected and does not disturb the address sequence.
    cycle(1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 16'd0, 2'd0);
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'h55, 2'd0);
    chk("feed_wr_err", 64'(herr), 64'd1);
    chk("feed_wr_a_addr", 64'(a_addr), 64'({16'd0, 16'd1}));
    idle(1);
    chk("feed_wr_err_clr", 64'(herr), 64'd0);
    idle(22);

    // Reset in the middle of drain, then a k_len=0 run.
    cycle(1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 16'd0, 2'd0);
    idle(5);
    cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 2'd0);
    chk("mid_rst_busy", 64'({busy, done}), 64'd0);
    chk("mid_rst_a_addr", 64'(a_addr), 64'({16'd6, 16'd6}));
    cycle(1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 2'd0);
    chk("k0_a_en", 64'(a_en), 64'd0);
    got = 0;
    for (int i = 2; i <= 40; i++) begin
      idle(1);
      if (done) begin
        got = i;
        break;
      end
    end
    chk("k0_done_latency", 64'(got), 64'd17);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 19) == 0),
            16'($urandom_range(0, 5)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            16'($urandom),
            2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
